video_triangle_setup: RTL and testbench

- Triangle setup stage directly upstream of the video rasterizer. Inputs: three screen-space vertices latched from the bus vertex registers, plus a fire pulse.
- Computes the three edge-function coefficient sets, the signed doubled area and a clipped bounding box.
- Culls degenerate, back-facing and fully off-screen triangles.
- Hands each surviving triangle to the rasterizer over a valid/ready handshake.

---
 rtl/video_triangle_setup.sv | 235 +++++++++++++++++++++++
 tb/tb_video_triangle_setup.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_triangle_setup.sv
// rtl/video_triangle_setup.sv - triangle setup: edge coefficients, doubled area, clipped bbox, culling
// One shared multiplier builds the edge constants over six cycles ahead of the cull decision.
module video_triangle_setup #(
   parameter int COORD_BITS = 12,
   parameter int GRID_W     = 40,
   parameter int GRID_H     = 25,
   parameter bit CULL_BACK  = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        fire,
   input  logic [COORD_BITS-1:0]       a_x,
   input  logic [COORD_BITS-1:0]       a_y,
   input  logic [COORD_BITS-1:0]       b_x,
   input  logic [COORD_BITS-1:0]       b_y,
   input  logic [COORD_BITS-1:0]       c_x,
   input  logic [COORD_BITS-1:0]       c_y,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [COORD_BITS:0]         e0_a,
   output logic [COORD_BITS:0]         e0_b,
   output logic [COORD_BITS:0]         e1_a,
   output logic [COORD_BITS:0]         e1_b,
   output logic [COORD_BITS:0]         e2_a,
   output logic [COORD_BITS:0]         e2_b,
   output logic [2*COORD_BITS:0]       e0_c,
   output logic [2*COORD_BITS:0]       e1_c,
   output logic [2*COORD_BITS:0]       e2_c,
   output logic [2*COORD_BITS+2:0]     area,
   output logic [$clog2(GRID_W)-1:0]   min_x,
   output logic [$clog2(GRID_W)-1:0]   max_x,
   output logic [$clog2(GRID_H)-1:0]   min_y,
   output logic [$clog2(GRID_H)-1:0]   max_y,
   output logic                        culled,
   output logic [1:0]                  cull_reason
);

   localparam int CB = COORD_BITS;
   localparam int EW = CB + 1;
   localparam int CW = 2*CB + 1;
   localparam int AW = 2*CB + 3;
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam logic signed [CB-1:0] GW    = CB'(GRID_W);
   localparam logic signed [CB-1:0] GH    = CB'(GRID_H);
   localparam logic signed [CB-1:0] GW_M1 = CB'(GRID_W - 1);
   localparam logic signed [CB-1:0] GH_M1 = CB'(GRID_H - 1);

   typedef enum logic [2:0] {IDLE, MUL, AREA, DECIDE, OUT} state_t;

   state_t                 state, state_nx;
   logic [2:0]             cnt;
   logic signed [CB-1:0]   x0, y0, x1, y1, x2, y2;
   logic signed [CB-1:0]   bx_lo, bx_hi, by_lo, by_hi;
   logic signed [CB-1:0]   mul_a, mul_b;
   logic signed [2*CB-1:0] prod;
   logic [CW-1:0]          prod_c;
   logic [1:0]             reason;

   function automatic logic signed [CB-1:0] min3(input logic signed [CB-1:0] p,
                                                 input logic signed [CB-1:0] q,
                                                 input logic signed [CB-1:0] r);
      logic signed [CB-1:0] m;
      m = (p < q) ? p : q;
      return (r < m) ? r : m;
   endfunction

   function automatic logic signed [CB-1:0] max3(input logic signed [CB-1:0] p,
                                                 input logic signed [CB-1:0] q,
                                                 input logic signed [CB-1:0] r);
      logic signed [CB-1:0] m;
      m = (p > q) ? p : q;
      return (r > m) ? r : m;
   endfunction

   function automatic logic [CB-1:0] clamp(input logic signed [CB-1:0] v,
                                           input logic signed [CB-1:0] hi);
      if (v[CB-1])
         return '0;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

   // Product order pairs up so each constant is finished two cycles after it starts.
   always_comb begin
      mul_a = x0;
      mul_b = y1;
      case (cnt)
         3'd1:    begin mul_a = x1; mul_b = y0; end
         3'd2:    begin mul_a = x1; mul_b = y2; end
         3'd3:    begin mul_a = x2; mul_b = y1; end
         3'd4:    begin mul_a = x2; mul_b = y0; end
         3'd5:    begin mul_a = x0; mul_b = y2; end
         default: begin mul_a = x0; mul_b = y1; end
      endcase
   end

   assign prod   = (2*CB)'(mul_a) * (2*CB)'(mul_b);
   assign prod_c = CW'(prod);

   always_comb begin
      reason = 2'd0;
      if (area == '0)
         reason = 2'd1;
      else if (area[AW-1] && CULL_BACK)
         reason = 2'd2;
      else if (bx_hi[CB-1] || by_hi[CB-1] || (bx_lo >= GW) || (by_lo >= GH))
         reason = 2'd3;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (fire) state_nx = MUL;
         MUL:     if (cnt == 3'd5) state_nx = AREA;
         AREA:    state_nx = DECIDE;
         DECIDE:  state_nx = (reason != 2'd0) ? IDLE : OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         x0          <= '0;
         y0          <= '0;
         x1          <= '0;
         y1          <= '0;
         x2          <= '0;
         y2          <= '0;
         bx_lo       <= '0;
         bx_hi       <= '0;
         by_lo       <= '0;
         by_hi       <= '0;
         e0_a        <= '0;
         e0_b        <= '0;
         e1_a        <= '0;
         e1_b        <= '0;
         e2_a        <= '0;
         e2_b        <= '0;
         e0_c        <= '0;
         e1_c        <= '0;
         e2_c        <= '0;
         area        <= '0;
         min_x       <= '0;
         max_x       <= '0;
         min_y       <= '0;
         max_y       <= '0;
         culled      <= 1'b0;
         cull_reason <= 2'd0;
      end else begin
         culled <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  x0          <= a_x;
                  y0          <= a_y;
                  x1          <= b_x;
                  y1          <= b_y;
                  x2          <= c_x;
                  y2          <= c_y;
                  cnt         <= '0;
                  cull_reason <= 2'd0;
               end
            end
            MUL: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd0) begin
                  e0_a <= EW'(y0) - EW'(y1);
                  e0_b <= EW'(x1) - EW'(x0);
                  e1_a <= EW'(y1) - EW'(y2);
                  e1_b <= EW'(x2) - EW'(x1);
                  e2_a <= EW'(y2) - EW'(y0);
                  e2_b <= EW'(x0) - EW'(x2);
               end
               case (cnt)
                  3'd0:    e0_c <= prod_c;
                  3'd1:    e0_c <= e0_c - prod_c;
                  3'd2:    e1_c <= prod_c;
                  3'd3:    e1_c <= e1_c - prod_c;
                  3'd4:    e2_c <= prod_c;
                  default: e2_c <= e2_c - prod_c;
               endcase
            end
            AREA: begin
               area  <= AW'($signed(e0_c)) + AW'($signed(e1_c)) + AW'($signed(e2_c));
               bx_lo <= min3(x0, x1, x2);
               bx_hi <= max3(x0, x1, x2);
               by_lo <= min3(y0, y1, y2);
               by_hi <= max3(y0, y1, y2);
            end
            DECIDE: begin
               if (reason != 2'd0) begin
                  culled      <= 1'b1;
                  cull_reason <= reason;
               end else begin
                  // Only reachable with a negative area when back faces are kept.
                  if (area[AW-1]) begin
                     e0_a <= -e0_a;
                     e0_b <= -e0_b;
                     e1_a <= -e1_a;
                     e1_b <= -e1_b;
                     e2_a <= -e2_a;
                     e2_b <= -e2_b;
                     e0_c <= -e0_c;
                     e1_c <= -e1_c;
                     e2_c <= -e2_c;
                     area <= -area;
                  end
                  min_x <= XW'(clamp(bx_lo, GW_M1));
                  max_x <= XW'(clamp(bx_hi, GW_M1));
                  min_y <= YW'(clamp(by_lo, GH_M1));
                  max_y <= YW'(clamp(by_hi, GH_M1));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_video_triangle_setup.sv
// tb/tb_video_triangle_setup.sv - directed bench for video_triangle_setup, both cull modes
module tb_video_triangle_setup;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        fire;
   logic        out_ready;
   logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

   logic        p_busy, p_out_valid, p_culled;
   logic [12:0] p_e0_a, p_e0_b, p_e1_a, p_e1_b, p_e2_a, p_e2_b;
   logic [24:0] p_e0_c, p_e1_c, p_e2_c;
   logic [26:0] p_area;
   logic [5:0]  p_min_x, p_max_x;
   logic [4:0]  p_min_y, p_max_y;
   logic [1:0]  p_cull_reason;

   logic        n_busy, n_out_valid, n_culled;
   logic [12:0] n_e0_a, n_e0_b, n_e1_a, n_e1_b, n_e2_a, n_e2_b;
   logic [24:0] n_e0_c, n_e1_c, n_e2_c;
   logic [26:0] n_area;
   logic [5:0]  n_min_x, n_max_x;
   logic [4:0]  n_min_y, n_max_y;
   logic [1:0]  n_cull_reason;

   int errors = 0;
   int checks = 0;

   video_triangle_setup #(.COORD_BITS(12), .GRID_W(40), .GRID_H(25), .CULL_BACK(1'b1)) dut (
      .clock(clock), .reset_n(reset_n), .fire(fire),
      .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y), .c_x(c_x), .c_y(c_y),
      .busy(p_busy), .out_valid(p_out_valid), .out_ready(out_ready),
      .e0_a(p_e0_a), .e0_b(p_e0_b), .e1_a(p_e1_a), .e1_b(p_e1_b), .e2_a(p_e2_a), .e2_b(p_e2_b),
      .e0_c(p_e0_c), .e1_c(p_e1_c), .e2_c(p_e2_c), .area(p_area),
      .min_x(p_min_x), .max_x(p_max_x), .min_y(p_min_y), .max_y(p_max_y),
      .culled(p_culled), .cull_reason(p_cull_reason)
   );

   video_triangle_setup #(.COORD_BITS(12), .GRID_W(40), .GRID_H(25), .CULL_BACK(1'b0)) dut_flip (
      .clock(clock), .reset_n(reset_n), .fire(fire),
      .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y), .c_x(c_x), .c_y(c_y),
      .busy(n_busy), .out_valid(n_out_valid), .out_ready(out_ready),
      .e0_a(n_e0_a), .e0_b(n_e0_b), .e1_a(n_e1_a), .e1_b(n_e1_b), .e2_a(n_e2_a), .e2_b(n_e2_b),
      .e0_c(n_e0_c), .e1_c(n_e1_c), .e2_c(n_e2_c), .area(n_area),
      .min_x(n_min_x), .max_x(n_max_x), .min_y(n_min_y), .max_y(n_max_y),
      .culled(n_culled), .cull_reason(n_cull_reason)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int w, input int exp);
      logic [31:0] e;
      e = 32'(exp) & ((32'd1 << w) - 32'd1);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
   endtask

   task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
      a_x = 12'(ax);
      a_y = 12'(ay);
      b_x = 12'(bx);
      b_y = 12'(by);
      c_x = 12'(cx);
      c_y = 12'(cy);
   endtask

   task automatic launch(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
      set_tri(ax, ay, bx, by, cx, cy);
      fire = 1'b1;
      tick();
      fire = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      fire      = 1'b0;
      out_ready = 1'b1;
      set_tri(0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk("rst_busy", p_busy, 1, 0);
      chk("rst_valid", p_out_valid, 1, 0);
      chk("rst_culled", p_culled, 1, 0);
      chk("rst_reason", p_cull_reason, 2, 0);
      chk("rst_area", p_area, 27, 0);
      chk("rst_max_x", p_max_x, 6, 0);
      reset_n = 1'b1;
      tick();

      // front-facing, exact latency
      launch(0, 0, 10, 0, 0, 10);
      repeat (7) tick();
      chk("ff_not_early", p_out_valid, 1, 0);
      chk("ff_busy", p_busy, 1, 1);
      tick();
      chk("ff_valid", p_out_valid, 1, 1);
      chk("ff_e0_a", p_e0_a, 13, 0);
      chk("ff_e0_b", p_e0_b, 13, 10);
      chk("ff_e0_c", p_e0_c, 25, 0);
      chk("ff_e1_a", p_e1_a, 13, -10);
      chk("ff_e1_b", p_e1_b, 13, -10);
      chk("ff_e1_c", p_e1_c, 25, 100);
      chk("ff_e2_a", p_e2_a, 13, 10);
      chk("ff_e2_b", p_e2_b, 13, 0);
      chk("ff_e2_c", p_e2_c, 25, 0);
      chk("ff_area", p_area, 27, 100);
      chk("ff_min_x", p_min_x, 6, 0);
      chk("ff_max_x", p_max_x, 6, 10);
      chk("ff_min_y", p_min_y, 5, 0);
      chk("ff_max_y", p_max_y, 5, 10);
      chk("ff_culled", p_culled, 1, 0);
      tick();
      chk("ff_done_valid", p_out_valid, 1, 0);
      chk("ff_done_busy", p_busy, 1, 0);

      // back-facing: culled with CULL_BACK=1, flipped with CULL_BACK=0
      launch(0, 0, 0, 10, 10, 0);
      repeat (8) tick();
      chk("bf_culled", p_culled, 1, 1);
      chk("bf_reason", p_cull_reason, 2, 2);
      chk("bf_valid", p_out_valid, 1, 0);
      chk("bf_busy", p_busy, 1, 0);
      chk("bf0_valid", n_out_valid, 1, 1);
      chk("bf0_area", n_area, 27, 100);
      chk("bf0_e0_a", n_e0_a, 13, 10);
      chk("bf0_e0_b", n_e0_b, 13, 0);
      chk("bf0_e1_a", n_e1_a, 13, -10);
      chk("bf0_e1_b", n_e1_b, 13, -10);
      chk("bf0_e1_c", n_e1_c, 25, 100);
      chk("bf0_e2_a", n_e2_a, 13, 0);
      chk("bf0_e2_b", n_e2_b, 13, 10);
      chk("bf0_max_y", n_max_y, 5, 10);
      tick();
      chk("bf_pulse_end", p_culled, 1, 0);
      chk("bf_reason_held", p_cull_reason, 2, 2);
      chk("bf0_done", n_out_valid, 1, 0);

      // degenerate
      launch(1, 1, 5, 5, 9, 9);
      repeat (8) tick();
      chk("dg_culled", p_culled, 1, 1);
      chk("dg_reason", p_cull_reason, 2, 1);
      chk("dg0_reason", n_cull_reason, 2, 1);
      chk("dg_valid", p_out_valid, 1, 0);
      tick();

      // clipping
      launch(-5, -5, 50, -5, -5, 30);
      repeat (8) tick();
      chk("cl_valid", p_out_valid, 1, 1);
      chk("cl_area", p_area, 27, 1925);
      chk("cl_e0_c", p_e0_c, 25, 275);
      chk("cl_e1_c", p_e1_c, 25, 1475);
      chk("cl_e1_a", p_e1_a, 13, -35);
      chk("cl_min_x", p_min_x, 6, 0);
      chk("cl_max_x", p_max_x, 6, 39);
      chk("cl_min_y", p_min_y, 5, 0);
      chk("cl_max_y", p_max_y, 5, 24);
      tick();

      // fully right of the grid
      launch(45, 0, 60, 0, 45, 10);
      repeat (8) tick();
      chk("os_culled", p_culled, 1, 1);
      chk("os_reason", p_cull_reason, 2, 3);
      chk("os_valid", p_out_valid, 1, 0);
      tick();

      // backpressure with an ignored second fire
      out_ready = 1'b0;
      launch(0, 0, 10, 0, 0, 10);
      repeat (8) tick();
      chk("bp_valid", p_out_valid, 1, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            set_tri(1, 1, 5, 5, 9, 9);
            fire = 1'b1;
         end
         tick();
         fire = 1'b0;
         chk("bp_hold_valid", p_out_valid, 1, 1);
         chk("bp_hold_busy", p_busy, 1, 1);
         chk("bp_hold_area", p_area, 27, 100);
         chk("bp_hold_e1_c", p_e1_c, 25, 100);
         chk("bp_hold_max_x", p_max_x, 6, 10);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", p_out_valid, 1, 0);
      chk("bp_release_busy", p_busy, 1, 0);
      repeat (10) tick();
      chk("bp_ignored_busy", p_busy, 1, 0);
      chk("bp_ignored_reason", p_cull_reason, 2, 0);
      chk("bp_ignored_area", p_area, 27, 100);

      // asynchronous reset during MUL
      launch(-5, -5, 50, -5, -5, 30);
      repeat (2) tick();
      chk("mr_busy_pre", p_busy, 1, 1);
      reset_n = 1'b0;
      #1;
      chk("mr_busy", p_busy, 1, 0);
      chk("mr_valid", p_out_valid, 1, 0);
      chk("mr_area", p_area, 27, 0);
      chk("mr_e1_a", p_e1_a, 13, 0);
      chk("mr_e0_c", p_e0_c, 25, 0);
      chk("mr_max_x", p_max_x, 6, 0);
      chk("mr_max_y", p_max_y, 5, 0);
      chk("mr_culled", p_culled, 1, 0);
      tick();
      reset_n = 1'b1;
      repeat (10) begin
         tick();
         chk("mr_no_pulse", p_culled, 1, 0);
      end
      chk("mr_idle_busy", p_busy, 1, 0);

      // recovery after reset
      launch(0, 0, 10, 0, 0, 10);
      repeat (8) tick();
      chk("rc_valid", p_out_valid, 1, 1);
      chk("rc_area", p_area, 27, 100);
      chk("rc_e1_c", p_e1_c, 25, 100);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
